// File: rtl/memory_pkg.sv
// Shared types for the data-memory path: access sizes, error codes and LSU states.
// Also holds small lane helpers used by the load/store unit.
package memory_pkg;

  localparam int MEM_ADDR_WIDTH  = 32;
  localparam int MEM_WORD_WIDTH  = 32;
  localparam int ERR_ENUMS_WIDTH = 2;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } e_mem_size;

  typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
    ERR_NONE         = 2'b00,
    ERR_BAD_SIZE     = 2'b01,
    ERR_OUT_OF_RANGE = 2'b10
  } e_memory_error_codes;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FIRST  = 2'b01,
    ST_SECOND = 2'b10,
    ST_DONE   = 2'b11
  } e_lsu_state;

  function automatic logic [3:0] size_mask(input e_mem_size size);
    case (size)
      SIZE_WORD: size_mask = 4'b1111;
      SIZE_HALF: size_mask = 4'b0011;
      SIZE_BYTE: size_mask = 4'b0001;
      default:   size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input e_mem_size size);
    case (size)
      SIZE_WORD: size_bytes = 3'd4;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_BYTE: size_bytes = 3'd1;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request/response and data-memory signals of the load/store unit.
// slave = the unit itself, master = core plus memory environment.
interface load_store_unit_if
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_WORD_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  e_memory_error_codes   rsp_err;
  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational little-endian lane logic: byte-enable mask over two words,
// store-data steering, and load-data extraction with sign/zero extension.
module lsu_byte_lane
  import memory_pkg::*;
(
  input  logic [1:0]  off,
  input  e_mem_size   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [7:0]  mask8,
  output logic        split,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata
);

  logic [63:0] wdata64_s;
  logic [31:0] rd_sh_s;

  // Lane mask, store steering and load extraction.
  always_comb begin
    mask8     = {4'b0000, size_mask(size)} << off;
    split     = |mask8[7:4];
    wdata64_s = {32'h0000_0000, wdata} << {off, 3'b000};
    wdata_lo  = wdata64_s[31:0];
    wdata_hi  = wdata64_s[63:32];
    rd_sh_s   = 32'({rd_hi, rd_lo} >> {off, 3'b000});
    case (size)
      SIZE_WORD: rdata = rd_sh_s;
      SIZE_HALF: begin
        if (is_unsigned) rdata = {16'h0000, rd_sh_s[15:0]};
        else             rdata = {{16{rd_sh_s[15]}}, rd_sh_s[15:0]};
      end
      SIZE_BYTE: begin
        if (is_unsigned) rdata = {24'h00_0000, rd_sh_s[7:0]};
        else             rdata = {{24{rd_sh_s[7]}}, rd_sh_s[7:0]};
      end
      default:   rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one byte/half/word request into one or two
// word-aligned memory accesses and returns an extended, registered response.
module load_store_unit
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_WORD_WIDTH,
  parameter int MEM_BYTES  = 65536
) (
  input logic               clk,
  input logic               rstn,
  load_store_unit_if.slave  bus
);

  e_lsu_state          state_r;
  e_memory_error_codes err_r;
  e_mem_size           size_r;
  logic [1:0]          off_r;
  logic                we_r;
  logic                uns_r;
  logic                cap_lo_r;
  logic                cap_hi_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [DATA_WIDTH-1:0] hi_r;

  logic                accept_s;
  logic [1:0]          sel_off_s;
  e_mem_size           sel_size_s;
  logic                sel_uns_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [DATA_WIDTH-1:0] lo_s;
  logic [DATA_WIDTH-1:0] hi_s;
  logic [ADDR_WIDTH:0] last_s;
  e_memory_error_codes err_s;
  logic [7:0]          mask8_s;
  logic                split_s;
  logic [DATA_WIDTH-1:0] wdata_lo_s;
  logic [DATA_WIDTH-1:0] wdata_hi_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign accept_s = bus.req_valid && bus.req_ready;

  // In IDLE the lane logic sees the live request; afterwards the latched one.
  always_comb begin
    if (state_r == ST_IDLE) begin
      sel_off_s   = bus.req_addr[1:0];
      sel_size_s  = e_mem_size'(bus.req_size);
      sel_uns_s   = bus.req_unsigned;
      sel_wdata_s = bus.req_wdata;
    end else begin
      sel_off_s   = off_r;
      sel_size_s  = size_r;
      sel_uns_s   = uns_r;
      sel_wdata_s = wdata_r;
    end
    // Read data arriving this cycle bypasses the buffer so DONE sees it.
    lo_s = cap_lo_r ? bus.mem_rdata : lo_r;
    hi_s = cap_hi_r ? bus.mem_rdata : hi_r;
  end

  // Request validation; the extra address bit catches 32-bit wrap-around.
  always_comb begin
    last_s = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(size_bytes(e_mem_size'(bus.req_size)))
           - (ADDR_WIDTH+1)'(1);
    if (e_mem_size'(bus.req_size) == SIZE_RSVD) begin
      err_s = ERR_BAD_SIZE;
    end else if (last_s >= (ADDR_WIDTH+1)'(MEM_BYTES)) begin
      err_s = ERR_OUT_OF_RANGE;
    end else begin
      err_s = ERR_NONE;
    end
  end

  lsu_byte_lane u_lane (
    .off         (sel_off_s),
    .size        (sel_size_s),
    .is_unsigned (sel_uns_s),
    .wdata       (sel_wdata_s),
    .rd_lo       (lo_s),
    .rd_hi       (hi_s),
    .mask8       (mask8_s),
    .split       (split_s),
    .wdata_lo    (wdata_lo_s),
    .wdata_hi    (wdata_hi_s),
    .rdata       (rdata_s)
  );

  // Control FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      err_r         <= ERR_NONE;
      size_r        <= SIZE_WORD;
      off_r         <= 2'b00;
      we_r          <= 1'b0;
      uns_r         <= 1'b0;
      cap_lo_r      <= 1'b0;
      cap_hi_r      <= 1'b0;
      wdata_r       <= '0;
      lo_r          <= '0;
      hi_r          <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= ERR_NONE;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      cap_lo_r      <= 1'b0;
      cap_hi_r      <= 1'b0;
      if (cap_lo_r) lo_r <= bus.mem_rdata;
      if (cap_hi_r) hi_r <= bus.mem_rdata;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            size_r        <= e_mem_size'(bus.req_size);
            off_r         <= bus.req_addr[1:0];
            we_r          <= bus.req_we;
            uns_r         <= bus.req_unsigned;
            wdata_r       <= bus.req_wdata;
            err_r         <= err_s;
            bus.req_ready <= 1'b0;
            if (err_s != ERR_NONE) begin
              state_r <= ST_DONE;
            end else begin
              state_r       <= ST_FIRST;
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_be    <= mask8_s[3:0];
              bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_wdata <= wdata_lo_s;
            end
          end
        end
        ST_FIRST: begin
          if (bus.mem_ready) begin
            cap_lo_r <= !we_r;
            if (split_s) begin
              state_r       <= ST_SECOND;
              bus.mem_be    <= mask8_s[7:4];
              bus.mem_addr  <= bus.mem_addr + ADDR_WIDTH'(4);
              bus.mem_wdata <= wdata_hi_s;
            end else begin
              state_r    <= ST_DONE;
              bus.mem_en <= 1'b0;
              bus.mem_we <= 1'b0;
              bus.mem_be <= 4'b0000;
            end
          end
        end
        ST_SECOND: begin
          if (bus.mem_ready) begin
            cap_hi_r   <= !we_r;
            state_r    <= ST_DONE;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_be <= 4'b0000;
          end
        end
        ST_DONE: begin
          state_r       <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= err_r;
          if (we_r || (err_r != ERR_NONE)) bus.rsp_rdata <= '0;
          else                             bus.rsp_rdata <= rdata_s;
        end
        default: begin
          state_r       <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-array memory model, access log,
// and immediate-assertion checks against hand-computed results.
module tb_load_store_unit;
  import memory_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(65536)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_model [0:16383];
  logic [31:0] rdata_q;
  logic [31:0] log_addr [$];
  logic [31:0] log_be [$];
  logic [31:0] log_wdata [$];

  assign bus.mem_rdata = rdata_q;

  // Memory model: one-cycle read latency, byte-enabled writes, access log.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_ready) begin
      log_addr.push_back(bus.mem_addr);
      log_be.push_back({28'h0, bus.mem_be});
      log_wdata.push_back(bus.mem_wdata);
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) mem_model[bus.mem_addr[15:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_model[bus.mem_addr[15:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output logic [31:0] rdata, output logic [1:0] err, output int lat);
    logic [31:0] snap_addr;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;
    log_addr.delete();
    log_be.delete();
    log_wdata.delete();
    lat   = 0;
    rdata = 32'h0;
    err   = 2'b00;
    snap_addr = 32'h0; snap_be = 4'h0; snap_wdata = 32'h0;
    @(negedge clk);
    check("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n <= stall) bus.mem_ready = 1'b0;
      else            bus.mem_ready = 1'b1;
      if (stall > 0 && n == 1) begin
        snap_addr = bus.mem_addr; snap_be = bus.mem_be; snap_wdata = bus.mem_wdata;
        check("stall_en", {31'h0, bus.mem_en}, 32'h1);
      end else if (stall > 0 && n <= stall + 1) begin
        check("stall_en", {31'h0, bus.mem_en}, 32'h1);
        check("stall_addr", bus.mem_addr, snap_addr);
        check("stall_be", {28'h0, bus.mem_be}, {28'h0, snap_be});
        check("stall_wdata", bus.mem_wdata, snap_wdata);
        check("stall_ready", {31'h0, bus.req_ready}, 32'h0);
      end
      if (bus.rsp_valid) begin
        lat   = n;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        break;
      end
    end
    check("rsp_seen", {31'h0, lat != 0}, 32'h1);
    @(negedge clk);
    check("rsp_pulse_one", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  logic [31:0] rd;
  logic [1:0]  er;
  int          lat;
  logic        seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    rstn = 1'b1;

    do_req(1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, 0, rd, er, lat);
    check("sw_lat", 32'(lat), 32'd3);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", {30'h0, er}, 32'h0);
    check("sw_count", 32'(log_addr.size()), 32'd1);
    check("sw_addr", log_addr[0], 32'h100);
    check("sw_be", log_be[0], 32'hF);
    check("sw_wdata", log_wdata[0], 32'hDEADBEEF);

    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, rd, er, lat);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {30'h0, er}, 32'h0);
    check("lw_addr", log_addr[0], 32'h100);
    check("lw_be", log_be[0], 32'hF);

    do_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h80000000, 0, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 0, rd, er, lat);
    check("lb_be", log_be[0], 32'h8);
    check("lb_addr", log_addr[0], 32'h100);
    check("lb_rdata", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 0, rd, er, lat);
    check("lbu_rdata", rd, 32'h00000080);

    do_req(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000A1B2, 0, rd, er, lat);
    check("sh_split_count", 32'(log_addr.size()), 32'd2);
    check("sh_addr0", log_addr[0], 32'h100);
    check("sh_be0", log_be[0], 32'h8);
    check("sh_wdata0", log_wdata[0], 32'hB2000000);
    check("sh_addr1", log_addr[1], 32'h104);
    check("sh_be1", log_be[1], 32'h1);
    check("sh_wdata1", log_wdata[1], 32'h000000A1);
    check("sh_lat", 32'(lat), 32'd4);
    do_req(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, rd, er, lat);
    check("lh_split_rdata", rd, 32'hFFFFA1B2);
    check("lh_split_lat", 32'(lat), 32'd4);

    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, rd, er, lat);
    check("bad_size_err", {30'h0, er}, 32'h1);
    check("bad_size_lat", 32'(lat), 32'd2);
    check("bad_size_noacc", 32'(log_addr.size()), 32'd0);
    check("bad_size_rdata", rd, 32'h0);

    do_req(1'b0, 2'b00, 1'b0, 32'h0000FFFE, 32'h0, 0, rd, er, lat);
    check("oor_err", {30'h0, er}, 32'h2);
    check("oor_noacc", 32'(log_addr.size()), 32'd0);
    check("oor_lat", 32'(lat), 32'd2);
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFFFFFE, 32'h0, 0, rd, er, lat);
    check("wrap_err", {30'h0, er}, 32'h2);
    check("wrap_noacc", 32'(log_addr.size()), 32'd0);

    do_req(1'b1, 2'b10, 1'b0, 32'h0000FFFF, 32'h0000005A, 0, rd, er, lat);
    check("edge_sb_err", {30'h0, er}, 32'h0);
    check("edge_sb_addr", log_addr[0], 32'h0000FFFC);
    check("edge_sb_wdata", log_wdata[0], 32'h5A000000);
    do_req(1'b0, 2'b10, 1'b1, 32'h0000FFFF, 32'h0, 0, rd, er, lat);
    check("edge_lbu_rdata", rd, 32'h0000005A);

    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 3, rd, er, lat);
    check("stall_lat", 32'(lat), 32'd6);
    check("stall_rdata", rd, 32'hB2000000);

    do_req(1'b1, 2'b00, 1'b0, 32'h200, 32'h12345678, 0, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h103;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_second_addr", bus.mem_addr, 32'h104);
    check("rst_mid_second_en", {31'h0, bus.mem_en}, 32'h1);
    rstn = 1'b0;
    #1;
    check("rst_mid_en_drop", {31'h0, bus.mem_en}, 32'h0);
    check("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", {31'h0, seen}, 32'h0);

    do_req(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 0, rd, er, lat);
    check("post_rst_rdata", rd, 32'h12345678);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_err", {30'h0, er}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
